pong_game_controller: RTL and testbench
=======================================

PONG_GAME_CONTROLLER -- requirements
Module: pong_game_controller

Interface
REQ-001 SHALL have parameter WIN_POINTS, default 7, meaning the points that end a match (legal range 1..15).
REQ-002 SHALL have parameter SERVE_DELAY, default 100_000_000, meaning the clock cycles the ball stays frozen before each serve (legal range 1..2^27-1).
REQ-003 SHALL have port CLK_100MHz, input, 1, the single system clock.
REQ-004 SHALL have port Reset, input, 1; reset is asynchronous and active-low.
REQ-005 SHALL have port StartBtn, input, 1, raw user start/pause button.
REQ-006 SHALL have ports PScore and CScore, input, 1 each, scoring flags from the ball logic (level, possibly held high several cycles).
REQ-007 SHALL have port start, output, 1, game-run enable to the clock divider.
REQ-008 SHALL have port win, output, 1, high when the match is over.
REQ-009 SHALL have port Winner, output, 1, 1 = player won, 0 = computer won; valid only while win=1.
REQ-010 SHALL have ports PPoints and CPoints, output, 4 each, player and computer match points.
REQ-011 SHALL have port State, output, 3, current FSM state code for display/debug.

Function
REQ-012 SHALL pass StartBtn, PScore and CScore each through a 2-flop synchronizer, then a rising-edge detector (one-cycle pulse when sync output is 1 and its previous value was 0).
REQ-013 SHALL implement FSM states IDLE=0, SERVE=1, PLAY=2, POINT=3, PAUSE=4, GAMEOVER=5.
REQ-014 IDLE: start=0; a button pulse SHALL clear both point counters, load the serve counter and go to SERVE.
REQ-015 SERVE: start=0; the counter SHALL decrement each cycle; when it reaches 1 the FSM SHALL go to PLAY, giving exactly SERVE_DELAY cycles in SERVE.
REQ-016 PLAY: start=1.
 - PScore pulse only: PPoints+1, then POINT.
 - CScore pulse only: CPoints+1, then POINT.
 - Both pulses in the same cycle: no increment, reload serve counter, go to SERVE (rally replayed).
 - Button pulse with no score pulse: go to PAUSE.
 - Score pulse coincident with button pulse: the score wins and the button pulse is dropped.
REQ-017 PAUSE: start=0; counters held; a button pulse SHALL return the FSM to PLAY; score pulses are ignored.
REQ-018 POINT (one cycle): if PPoints==WIN_POINTS or CPoints==WIN_POINTS, go to GAMEOVER and latch Winner; otherwise reload the serve counter and go to SERVE.
REQ-019 GAMEOVER: start=0, win=1, points and Winner held; a button pulse SHALL clear points, clear win, load the serve counter and go to SERVE.
REQ-020 Score pulses outside PLAY SHALL be ignored.
REQ-021 Point counters SHALL never exceed WIN_POINTS; they cannot wrap.
REQ-022 All outputs SHALL be registered; outputs reflect a state change on the same edge that enters the state.
REQ-023 Latency: a StartBtn rise SHALL change the state on the 3rd rising clock edge after the rise (2 synchronizer flops plus 1 FSM register).
REQ-024 Undefined state codes SHALL recover to IDLE on the next cycle.

Reset
REQ-025 Reset low SHALL asynchronously force: state IDLE, start=0, win=0, Winner=0, PPoints=0, CPoints=0, serve counter=0, all synchronizer and edge flops=0.
REQ-026 Reset asserted mid-SERVE, PLAY or GAMEOVER SHALL abandon the match immediately; after release the block SHALL wait in IDLE for a button pulse.
REQ-027 The first clock edge after reset release SHALL NOT produce edge pulses from inputs that are already high until they have been observed low.

Structure
REQ-028 Package pong_pkg SHALL hold the state encoding, the 4-bit point width, the 27-bit serve-counter width and the WIN_POINTS/SERVE_DELAY defaults.
REQ-029 A single sub-module, edge_sync (2-flop synchronizer plus rising-edge pulse, same clock and reset), SHALL be instantiated three times.

Verification
REQ-030 Reset low, then release with StartBtn=1 held → State stays 0, start=0; drop and re-raise StartBtn → State=1 on the 3rd edge.
REQ-031 SERVE_DELAY=5: enter SERVE → start=0 for exactly 5 cycles, then start=1 and State=2.
REQ-032 WIN_POINTS=3, three isolated PScore pulses each held 4 cycles → PPoints 1,2,3 (one increment per pulse); after the third, win=1, Winner=1, State=5, start=0.
REQ-033 In PLAY, PScore and CScore rise in the same cycle → points unchanged, State=1; in PLAY, a StartBtn pulse → State=4 with CScore pulses ignored; a second StartBtn pulse → State=2.
REQ-034 Reset pulled low while PPoints=2 in PLAY → all outputs 0 and State=0 asynchronously, before the next clock edge.
REQ-035 In GAMEOVER, a StartBtn pulse → PPoints=CPoints=0, win=0, State=1.

Source files
------------

// File: rtl/pong_pkg.sv
// rtl/pong_pkg.sv - shared state encoding, widths and parameter defaults for the pong controller
package pong_pkg;

  localparam int POINT_W             = 4;
  localparam int SERVE_W             = 27;
  localparam int WIN_POINTS_DEFAULT  = 7;
  localparam int SERVE_DELAY_DEFAULT = 100_000_000;

  typedef enum logic [2:0] {
    ST_IDLE     = 3'd0,
    ST_SERVE    = 3'd1,
    ST_PLAY     = 3'd2,
    ST_POINT    = 3'd3,
    ST_PAUSE    = 3'd4,
    ST_GAMEOVER = 3'd5
  } state_e;

endpackage

// File: rtl/edge_sync.sv
// rtl/edge_sync.sv - 2-flop synchronizer with a one-cycle rising-edge pulse
module edge_sync (
  input  logic clk_i,
  input  logic rst_ni,
  input  logic async_i,
  output logic pulse_o
);

  logic       sync1_q;
  logic       sync2_q;
  logic       prev_q;
  logic       armed_q;
  logic [1:0] prime_q;

  // armed_q only sets once sync2_q holds a real sample that is low, so an
  // input already high when reset releases cannot fire a pulse.
  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      sync1_q <= 1'b0;
      sync2_q <= 1'b0;
      prev_q  <= 1'b0;
      armed_q <= 1'b0;
      prime_q <= 2'b00;
    end else begin
      sync1_q <= async_i;
      sync2_q <= sync1_q;
      prev_q  <= sync2_q;
      prime_q <= {prime_q[0], 1'b1};
      if (prime_q[1] && !sync2_q) begin
        armed_q <= 1'b1;
      end
    end
  end

  assign pulse_o = sync2_q & ~prev_q & armed_q;

endmodule

// File: rtl/pong_game_controller.sv
// rtl/pong_game_controller.sv - match FSM: serve delay, scoring, pause and game-over handling
module pong_game_controller
  import pong_pkg::*;
#(
  parameter int WIN_POINTS  = WIN_POINTS_DEFAULT,
  parameter int SERVE_DELAY = SERVE_DELAY_DEFAULT
) (
  input  logic               CLK_100MHz,
  input  logic               Reset,
  input  logic               StartBtn,
  input  logic               PScore,
  input  logic               CScore,
  output logic               start,
  output logic               win,
  output logic               Winner,
  output logic [POINT_W-1:0] PPoints,
  output logic [POINT_W-1:0] CPoints,
  output logic [2:0]         State
);

  localparam logic [POINT_W-1:0] WIN_P      = POINT_W'(WIN_POINTS);
  localparam logic [SERVE_W-1:0] SERVE_LOAD = SERVE_W'(SERVE_DELAY);

  logic btn_pulse;
  logic p_pulse;
  logic c_pulse;

  edge_sync u_btn_sync (.clk_i(CLK_100MHz), .rst_ni(Reset), .async_i(StartBtn), .pulse_o(btn_pulse));
  edge_sync u_p_sync   (.clk_i(CLK_100MHz), .rst_ni(Reset), .async_i(PScore),   .pulse_o(p_pulse));
  edge_sync u_c_sync   (.clk_i(CLK_100MHz), .rst_ni(Reset), .async_i(CScore),   .pulse_o(c_pulse));

  state_e               state_q;
  logic                 start_q;
  logic                 win_q;
  logic                 winner_q;
  logic [POINT_W-1:0]   ppoints_q;
  logic [POINT_W-1:0]   cpoints_q;
  logic [SERVE_W-1:0]   serve_cnt_q;

  always_ff @(posedge CLK_100MHz or negedge Reset) begin
    if (!Reset) begin
      state_q     <= ST_IDLE;
      start_q     <= 1'b0;
      win_q       <= 1'b0;
      winner_q    <= 1'b0;
      ppoints_q   <= '0;
      cpoints_q   <= '0;
      serve_cnt_q <= '0;
    end else begin
      case (state_q)
        ST_IDLE: begin
          start_q <= 1'b0;
          if (btn_pulse) begin
            ppoints_q   <= '0;
            cpoints_q   <= '0;
            serve_cnt_q <= SERVE_LOAD;
            state_q     <= ST_SERVE;
          end
        end

        ST_SERVE: begin
          if (serve_cnt_q <= SERVE_W'(1)) begin
            state_q <= ST_PLAY;
            start_q <= 1'b1;
          end else begin
            serve_cnt_q <= serve_cnt_q - SERVE_W'(1);
          end
        end

        // Score pulses take priority; a simultaneous button pulse is dropped.
        ST_PLAY: begin
          if (p_pulse && c_pulse) begin
            serve_cnt_q <= SERVE_LOAD;
            state_q     <= ST_SERVE;
            start_q     <= 1'b0;
          end else if (p_pulse) begin
            if (ppoints_q < WIN_P) begin
              ppoints_q <= ppoints_q + POINT_W'(1);
            end
            state_q <= ST_POINT;
            start_q <= 1'b0;
          end else if (c_pulse) begin
            if (cpoints_q < WIN_P) begin
              cpoints_q <= cpoints_q + POINT_W'(1);
            end
            state_q <= ST_POINT;
            start_q <= 1'b0;
          end else if (btn_pulse) begin
            state_q <= ST_PAUSE;
            start_q <= 1'b0;
          end
        end

        ST_POINT: begin
          if (ppoints_q == WIN_P || cpoints_q == WIN_P) begin
            state_q  <= ST_GAMEOVER;
            win_q    <= 1'b1;
            winner_q <= (ppoints_q == WIN_P);
          end else begin
            serve_cnt_q <= SERVE_LOAD;
            state_q     <= ST_SERVE;
          end
        end

        ST_PAUSE: begin
          if (btn_pulse) begin
            state_q <= ST_PLAY;
            start_q <= 1'b1;
          end
        end

        ST_GAMEOVER: begin
          if (btn_pulse) begin
            ppoints_q   <= '0;
            cpoints_q   <= '0;
            win_q       <= 1'b0;
            winner_q    <= 1'b0;
            serve_cnt_q <= SERVE_LOAD;
            state_q     <= ST_SERVE;
          end
        end

        default: begin
          state_q <= ST_IDLE;
          start_q <= 1'b0;
          win_q   <= 1'b0;
        end
      endcase
    end
  end

  assign start   = start_q;
  assign win     = win_q;
  assign Winner  = winner_q;
  assign PPoints = ppoints_q;
  assign CPoints = cpoints_q;
  assign State   = state_q;

endmodule

// File: tb/tb_pong_game_controller.sv
// tb/tb_pong_game_controller.sv - scoreboard bench for pong_game_controller (WIN_POINTS=3, SERVE_DELAY=5)
module tb_pong_game_controller;

  logic       clk;
  logic       Reset;
  logic       StartBtn;
  logic       PScore;
  logic       CScore;
  logic       start;
  logic       win;
  logic       Winner;
  logic [3:0] PPoints;
  logic [3:0] CPoints;
  logic [2:0] State;

  int n_cmp = 0;
  int n_bad = 0;

  typedef struct packed {
    logic [2:0] st;
    logic       start;
    logic       win;
    logic       winner;
    logic [3:0] pp;
    logic [3:0] cp;
  } snap_t;

  snap_t exp_q[$];
  snap_t obs_q[$];
  string tag_q[$];

  pong_game_controller #(.WIN_POINTS(3), .SERVE_DELAY(5)) dut (
    .CLK_100MHz(clk),
    .Reset     (Reset),
    .StartBtn  (StartBtn),
    .PScore    (PScore),
    .CScore    (CScore),
    .start     (start),
    .win       (win),
    .Winner    (Winner),
    .PPoints   (PPoints),
    .CPoints   (CPoints),
    .State     (State)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  function automatic snap_t mk(input int st, input int st_start, input int w, input int wn, input int pp, input int cp);
    snap_t s;
    s.st = 3'(st); s.start = 1'(st_start); s.win = 1'(w); s.winner = 1'(wn); s.pp = 4'(pp); s.cp = 4'(cp);
    return s;
  endfunction

  function automatic snap_t snap();
    snap_t s;
    s.st = State; s.start = start; s.win = win; s.winner = Winner; s.pp = PPoints; s.cp = CPoints;
    return s;
  endfunction

  task automatic tick(input int n);
    repeat (n) @(negedge clk);
  endtask

  task automatic record(input string tag, input snap_t e);
    exp_q.push_back(e);
    obs_q.push_back(snap());
    tag_q.push_back(tag);
  endtask

  task automatic wait_state(input logic [2:0] s, input int max_cycles);
    int n = 0;
    while (State !== s && n < max_cycles) begin
      tick(1);
      n++;
    end
  endtask

  task automatic test_reset();
    snap_t e, o;
    string t;
    Reset = 1'b0; StartBtn = 1'b1; PScore = 1'b0; CScore = 1'b0;
    tick(2);
    record("reset_state", mk(0, 0, 0, 0, 0, 0));
    tick(1);
    Reset = 1'b1;
    tick(6);
    record("held_btn_no_pulse", mk(0, 0, 0, 0, 0, 0));
    StartBtn = 1'b0;
    tick(4);
    StartBtn = 1'b1;
    tick(2);
    record("btn_before_3rd_edge", mk(0, 0, 0, 0, 0, 0));
    tick(1);
    record("btn_3rd_edge_serve", mk(1, 0, 0, 0, 0, 0));
    StartBtn = 1'b0;
    while (exp_q.size() > 0) begin
      e = exp_q.pop_front(); o = obs_q.pop_front(); t = tag_q.pop_front();
      if (!e.win) begin e.winner = 1'b0; o.winner = 1'b0; end
      n_cmp++;
      if (o !== e) begin
        n_bad++;
        $display("FAIL %s: got st=%0d start=%0d win=%0d winner=%0d pp=%0d cp=%0d, want st=%0d start=%0d win=%0d winner=%0d pp=%0d cp=%0d",
                 t, o.st, o.start, o.win, o.winner, o.pp, o.cp, e.st, e.start, e.win, e.winner, e.pp, e.cp);
      end
    end
  endtask

  task automatic test_serve();
    snap_t e, o;
    string t;
    for (int i = 0; i < 5; i++) begin
      record($sformatf("serve_cycle_%0d", i), mk(1, 0, 0, 0, 0, 0));
      tick(1);
    end
    record("serve_done_play", mk(2, 1, 0, 0, 0, 0));
    while (exp_q.size() > 0) begin
      e = exp_q.pop_front(); o = obs_q.pop_front(); t = tag_q.pop_front();
      if (!e.win) begin e.winner = 1'b0; o.winner = 1'b0; end
      n_cmp++;
      if (o !== e) begin
        n_bad++;
        $display("FAIL %s: got st=%0d start=%0d win=%0d winner=%0d pp=%0d cp=%0d, want st=%0d start=%0d win=%0d winner=%0d pp=%0d cp=%0d",
                 t, o.st, o.start, o.win, o.winner, o.pp, o.cp, e.st, e.start, e.win, e.winner, e.pp, e.cp);
      end
    end
  endtask

  task automatic test_player_wins();
    snap_t e, o;
    string t;
    for (int i = 1; i <= 3; i++) begin
      PScore = 1'b1;
      tick(3);
      record($sformatf("point_%0d", i), mk(3, 0, 0, 0, i, 0));
      tick(1);
      PScore = 1'b0;
      if (i < 3) begin
        wait_state(3'd2, 40);
        record($sformatf("play_after_point_%0d", i), mk(2, 1, 0, 0, i, 0));
      end else begin
        record("gameover", mk(5, 0, 1, 1, 3, 0));
      end
    end
    tick(5);
    record("gameover_held", mk(5, 0, 1, 1, 3, 0));
    while (exp_q.size() > 0) begin
      e = exp_q.pop_front(); o = obs_q.pop_front(); t = tag_q.pop_front();
      if (!e.win) begin e.winner = 1'b0; o.winner = 1'b0; end
      n_cmp++;
      if (o !== e) begin
        n_bad++;
        $display("FAIL %s: got st=%0d start=%0d win=%0d winner=%0d pp=%0d cp=%0d, want st=%0d start=%0d win=%0d winner=%0d pp=%0d cp=%0d",
                 t, o.st, o.start, o.win, o.winner, o.pp, o.cp, e.st, e.start, e.win, e.winner, e.pp, e.cp);
      end
    end
  endtask

  task automatic test_restart();
    snap_t e, o;
    string t;
    StartBtn = 1'b1;
    tick(3);
    record("restart_serve", mk(1, 0, 0, 0, 0, 0));
    StartBtn = 1'b0;
    wait_state(3'd2, 40);
    record("restart_play", mk(2, 1, 0, 0, 0, 0));
    while (exp_q.size() > 0) begin
      e = exp_q.pop_front(); o = obs_q.pop_front(); t = tag_q.pop_front();
      if (!e.win) begin e.winner = 1'b0; o.winner = 1'b0; end
      n_cmp++;
      if (o !== e) begin
        n_bad++;
        $display("FAIL %s: got st=%0d start=%0d win=%0d winner=%0d pp=%0d cp=%0d, want st=%0d start=%0d win=%0d winner=%0d pp=%0d cp=%0d",
                 t, o.st, o.start, o.win, o.winner, o.pp, o.cp, e.st, e.start, e.win, e.winner, e.pp, e.cp);
      end
    end
  endtask

  task automatic test_both_and_pause();
    snap_t e, o;
    string t;
    PScore = 1'b1; CScore = 1'b1;
    tick(3);
    record("both_replay", mk(1, 0, 0, 0, 0, 0));
    PScore = 1'b0; CScore = 1'b0;
    wait_state(3'd2, 40);
    record("replay_play", mk(2, 1, 0, 0, 0, 0));
    tick(2);
    StartBtn = 1'b1;
    tick(3);
    record("pause", mk(4, 0, 0, 0, 0, 0));
    StartBtn = 1'b0;
    tick(2);
    CScore = 1'b1;
    tick(4);
    CScore = 1'b0;
    tick(3);
    record("pause_ignores_cscore", mk(4, 0, 0, 0, 0, 0));
    StartBtn = 1'b1;
    tick(3);
    record("resume", mk(2, 1, 0, 0, 0, 0));
    StartBtn = 1'b0;
    tick(3);
    StartBtn = 1'b1; CScore = 1'b1;
    tick(3);
    record("score_beats_btn", mk(3, 0, 0, 0, 0, 1));
    StartBtn = 1'b0; CScore = 1'b0;
    wait_state(3'd2, 40);
    record("play_after_coincident", mk(2, 1, 0, 0, 0, 1));
    while (exp_q.size() > 0) begin
      e = exp_q.pop_front(); o = obs_q.pop_front(); t = tag_q.pop_front();
      if (!e.win) begin e.winner = 1'b0; o.winner = 1'b0; end
      n_cmp++;
      if (o !== e) begin
        n_bad++;
        $display("FAIL %s: got st=%0d start=%0d win=%0d winner=%0d pp=%0d cp=%0d, want st=%0d start=%0d win=%0d winner=%0d pp=%0d cp=%0d",
                 t, o.st, o.start, o.win, o.winner, o.pp, o.cp, e.st, e.start, e.win, e.winner, e.pp, e.cp);
      end
    end
  endtask

  task automatic test_async_reset();
    snap_t e, o;
    string t;
    for (int i = 1; i <= 2; i++) begin
      PScore = 1'b1;
      tick(4);
      PScore = 1'b0;
      wait_state(3'd2, 40);
    end
    record("pp2_play", mk(2, 1, 0, 0, 2, 1));
    #2;
    Reset = 1'b0;
    #1;
    record("async_reset", mk(0, 0, 0, 0, 0, 0));
    @(negedge clk);
    Reset = 1'b1;
    tick(5);
    record("idle_after_reset", mk(0, 0, 0, 0, 0, 0));
    while (exp_q.size() > 0) begin
      e = exp_q.pop_front(); o = obs_q.pop_front(); t = tag_q.pop_front();
      if (!e.win) begin e.winner = 1'b0; o.winner = 1'b0; end
      n_cmp++;
      if (o !== e) begin
        n_bad++;
        $display("FAIL %s: got st=%0d start=%0d win=%0d winner=%0d pp=%0d cp=%0d, want st=%0d start=%0d win=%0d winner=%0d pp=%0d cp=%0d",
                 t, o.st, o.start, o.win, o.winner, o.pp, o.cp, e.st, e.start, e.win, e.winner, e.pp, e.cp);
      end
    end
  endtask

  initial begin
    test_reset();
    test_serve();
    test_player_wins();
    test_restart();
    test_both_and_pause();
    test_async_reset();
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

  initial begin
    #500_000;
    $display("FAIL watchdog: got no completion, want completion before timeout");
    $fatal(1);
  end

endmodule
